// File: rtl/mesh_pkg.sv
// mesh_pkg: shared definitions for the mesh row link.
//   PACKET_WIDTH_DEF : default flit width
//   ptr_w(depth)     : FIFO pointer width (one extra wrap bit above the index)
//   occ_w(depth)     : occupancy field width (1 for passthrough)
//   col_lsb(c, w)    : LSB of column c inside a packed per-column vector
package mesh_pkg;

  localparam int PACKET_WIDTH_DEF = 64;

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth) + 1;
  endfunction

  function automatic int occ_w(input int depth);
    return (depth == 0) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic int col_lsb(input int col, input int width);
    return col * width;
  endfunction

endpackage

// File: rtl/link_fifo.sv
// link_fifo: one elastic channel of the mesh row link (DEPTH power of two >= 2).
//   clk, reset (async, active-low)
//   si/di/ro : upstream send, data, ready
//   so/dout/ri : downstream send, data, ready
//   occ      : number of buffered flits
// Every output decodes from registers only, so no ready/send path crosses
// the stage combinationally.
module link_fifo
  import mesh_pkg::*;
#(
  parameter  int PACKET_WIDTH = PACKET_WIDTH_DEF,
  parameter  int DEPTH        = 2,
  localparam int OCC_W        = occ_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    si,
  input  logic [PACKET_WIDTH-1:0] di,
  output logic                    ro,
  output logic                    so,
  output logic [PACKET_WIDTH-1:0] dout,
  input  logic                    ri,
  output logic [OCC_W-1:0]        occ
);

  localparam int PW = ptr_w(DEPTH);
  localparam int IW = PW - 1;

  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [PACKET_WIDTH-1:0] mem [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Pointers run modulo 2*DEPTH; the MSB distinguishes full from empty.
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign ro   = ~full;
  assign so   = ~empty;
  assign dout = mem[rd_ptr[IW-1:0]];
  assign occ  = wr_ptr - rd_ptr;

  assign push = si & ro;
  assign pop  = so & ri;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // Storage is cleared too so the head data reads as zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[IW-1:0]] <= di;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/mesh_row_link.sv
// mesh_row_link: buffered vertical link between two adjacent mesh rows.
//   clk, reset (async, active-low)
//   s2n_* : lower row -> upper row channel per column (si/di in, ro out,
//           so/do out, ri in)
//   n2s_* : upper row -> lower row channel per column, same roles
//   s2n_occ / n2s_occ : per-column occupancy, OCC_W bits per column
// Column c uses bit c of 1-bit vectors and bits [c*PACKET_WIDTH +: PACKET_WIDTH]
// of data vectors. DEPTH=0 turns every channel into plain wiring.
module mesh_row_link
  import mesh_pkg::*;
#(
  parameter int NUM_COLS     = 4,
  parameter int PACKET_WIDTH = PACKET_WIDTH_DEF,
  parameter int DEPTH        = 2,
  parameter int OCC_W        = occ_w(DEPTH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_COLS-1:0]              s2n_si,
  input  logic [NUM_COLS*PACKET_WIDTH-1:0] s2n_di,
  output logic [NUM_COLS-1:0]              s2n_ro,
  output logic [NUM_COLS-1:0]              s2n_so,
  output logic [NUM_COLS*PACKET_WIDTH-1:0] s2n_do,
  input  logic [NUM_COLS-1:0]              s2n_ri,
  input  logic [NUM_COLS-1:0]              n2s_si,
  input  logic [NUM_COLS*PACKET_WIDTH-1:0] n2s_di,
  output logic [NUM_COLS-1:0]              n2s_ro,
  output logic [NUM_COLS-1:0]              n2s_so,
  output logic [NUM_COLS*PACKET_WIDTH-1:0] n2s_do,
  input  logic [NUM_COLS-1:0]              n2s_ri,
  output logic [NUM_COLS*OCC_W-1:0]        s2n_occ,
  output logic [NUM_COLS*OCC_W-1:0]        n2s_occ
);

  if (DEPTH == 0) begin : g_pass
    assign s2n_so  = s2n_si;
    assign s2n_do  = s2n_di;
    assign s2n_ro  = s2n_ri;
    assign n2s_so  = n2s_si;
    assign n2s_do  = n2s_di;
    assign n2s_ro  = n2s_ri;
    assign s2n_occ = '0;
    assign n2s_occ = '0;
  end else begin : g_fifo
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
      link_fifo #(
        .PACKET_WIDTH(PACKET_WIDTH),
        .DEPTH       (DEPTH)
      ) u_s2n (
        .clk  (clk),
        .reset(reset),
        .si   (s2n_si[gi]),
        .di   (s2n_di[col_lsb(gi, PACKET_WIDTH) +: PACKET_WIDTH]),
        .ro   (s2n_ro[gi]),
        .so   (s2n_so[gi]),
        .dout (s2n_do[col_lsb(gi, PACKET_WIDTH) +: PACKET_WIDTH]),
        .ri   (s2n_ri[gi]),
        .occ  (s2n_occ[col_lsb(gi, OCC_W) +: OCC_W])
      );

      link_fifo #(
        .PACKET_WIDTH(PACKET_WIDTH),
        .DEPTH       (DEPTH)
      ) u_n2s (
        .clk  (clk),
        .reset(reset),
        .si   (n2s_si[gi]),
        .di   (n2s_di[col_lsb(gi, PACKET_WIDTH) +: PACKET_WIDTH]),
        .ro   (n2s_ro[gi]),
        .so   (n2s_so[gi]),
        .dout (n2s_do[col_lsb(gi, PACKET_WIDTH) +: PACKET_WIDTH]),
        .ri   (n2s_ri[gi]),
        .occ  (n2s_occ[col_lsb(gi, OCC_W) +: OCC_W])
      );
    end
  end

endmodule

// File: doc/mesh_row_link.md
# mesh_row_link

Parametrised, buffered vertical link stage placed between two adjacent mesh rows, one per row boundary. For each of NUM_COLS columns it carries two independent channels, south-to-north (s2n) and north-to-south (n2s), each through an elastic FIFO speaking the router send/ready protocol. This lets mesh height and column count grow without long combinational ready paths between rows. It adds occupancy status per channel and a zero-depth passthrough mode.

## Interface
- NUM_COLS, 4, columns served (≥1)
- PACKET_WIDTH, 64, flit width in bits
- DEPTH, 2, FIFO entries per channel; power of two ≥2, or 0 for passthrough
- OCC_W, $clog2(DEPTH+1) (1 when DEPTH=0), occupancy field width

Ports (column c occupies bit c of 1-bit vectors and bits [c*PACKET_WIDTH +: PACKET_WIDTH] of data vectors):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- s2n_si  in  NUM_COLS  send from lower row (its snso)
- s2n_di  in  NUM_COLS*PACKET_WIDTH  data from lower row (its sndo)
- s2n_ro  out  NUM_COLS  ready to lower row (its snro)
- s2n_so  out  NUM_COLS  send to upper row (its nssi)
- s2n_do  out  NUM_COLS*PACKET_WIDTH  data to upper row (its nsdi)
- s2n_ri  in  NUM_COLS  ready from upper row (its nsri)
- n2s_si, n2s_di, n2s_ro, n2s_so, n2s_do, n2s_ri: same set for the upper-to-lower direction
- s2n_occ  out  NUM_COLS*OCC_W  per-column s2n occupancy
- n2s_occ  out  NUM_COLS*OCC_W  per-column n2s occupancy

## Operation
- 2*NUM_COLS fully independent channels; no arbitration, no cross-channel coupling.
- Transfer rule, both sides: a flit moves on a rising edge where send=1 and ready=1. Otherwise nothing moves.
- Upstream holds data stable while send=1 and ready=0. The block does the same on its output side.
- Push: *_si & *_ro.
- Pop: *_so & *_ri.
- *_ro = (count < DEPTH).
- *_so = (count ≠ 0).
- *_do = head entry.
- All of *_ro, *_so and *_do decode from registers only. There is no combinational path from *_ri or *_si to any output.
- Storage: DEPTH-entry array.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits.
  - Wrap naturally modulo 2*DEPTH; index uses the low bits.
  - full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
- count = wr_ptr − rd_ptr, modulo 2^(ptr width); exported on *_occ.
- Simultaneous push and pop:
  - Not full and not empty: both occur; count unchanged.
  - Empty: only push is possible (so=0).
  - Full: only pop is possible (ro=0).
- DEPTH=0 (passthrough): *_so=*_si, *_do=*_di, *_ro=*_ri, *_occ=0. No state.
- Data is never dropped, duplicated or reordered within a channel.

## Timing
- Latency: a flit pushed at edge k is visible on *_so/*_do after edge k, so it can pop at edge k+1. There is no same-cycle fall-through.
- Throughput: 1 flit/cycle/channel sustained when DEPTH≥2 and downstream ready stays high.
- *_ro deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the first pop from full.
- Reset (reset=0, asynchronous):
  - Pointers go to 0: *_so=0, *_ro=1, *_occ=0.
  - *_do is held at 0 (storage reset).
- Reset asserted mid-operation discards all buffered flits immediately.
- Release is synchronous to the next edge. The first push can occur on the first edge with reset=1.

## Structure
- The shared package mesh_pkg holds:
  - the PACKET_WIDTH default;
  - the DEPTH-to-pointer-width and OCC_W derivation functions;
  - the column slice helper.
- Sub-module link_fifo: one channel with params PACKET_WIDTH and DEPTH, plus ports clk, reset, si, di, ro, so, do, ri, occ.
- Top level is a generate loop of 2*NUM_COLS link_fifo instances. The DEPTH=0 branch is pure wiring.

## Test plan
- Reset mid-traffic: fill column 2 s2n with 2 flits, pulse reset low between edges → s2n_so[2]=0, s2n_occ[2]=0 and s2n_ro[2]=1 immediately; no stale flit after release.
- Single flit, DEPTH=2: push 0xDEAD_BEEF_0000_0001 on s2n col 0 at edge 1 with s2n_ri=1 → s2n_so[0]=1 after edge 1, pop at edge 2, occ back to 0.
- Full/backpressure, DEPTH=4: n2s_ri[3]=0 and push 6 flits (0x10..0x15) → n2s_ro[3]=0 after the 4th push, occ=4, upstream stalls. Release ri → output order 0x10..0x15, no loss.
- Streaming, DEPTH=2: continuous pushes and ready on all 8 channels for 100 cycles → one flit per cycle per channel, per-channel order preserved, occ ≤ 1.
- Simultaneous push/pop at occ=1 with pointer wrap, DEPTH=2, 10 flits → occ stays 1, data matches the scoreboard across the wrap.
- DEPTH=0, NUM_COLS=8: random si/ri/di → outputs equal inputs in the same cycle, occ=0.
